// File: rtl/operand2_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand2_shift_stage
//  Description : Decodes the operand2 field of a data-processing instruction
//                into a barrel-shifter request. Decoded requests are held in
//                a 2-entry FIFO whose head drives the outputs directly.
//  Revision    : 1.0  initial release
// ============================================================================
module operand2_shift_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         imm_flag,
  input  logic         reg_shift,
  input  logic [11:0]  op2_field,
  input  logic [W-1:0] rm_data,
  input  logic [7:0]   rs_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] shift_data,
  output logic [4:0]   shamt,
  output logic [1:0]   control,
  output logic         shift32,
  output logic         shift_big,
  output logic         rrx
);

  // One record is {shift_data, shamt, control, shift32, shift_big, rrx}.
  localparam int REC_W = W + 10;

  logic [W-1:0]     dec_data;
  logic [4:0]       dec_shamt;
  logic [1:0]       dec_ctrl;
  logic             dec_s32;
  logic             dec_big;
  logic             dec_rrx;
  logic [REC_W-1:0] entry_d;

  logic [REC_W-1:0] mem_q [0:1];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push;
  logic             pop;
  logic [REC_W-1:0] head;

  // Operand2 decode: immediate rotate, immediate shift, or register shift.
  always_comb begin
    dec_data  = rm_data;
    dec_shamt = 5'd0;
    dec_ctrl  = op2_field[6:5];
    dec_s32   = 1'b0;
    dec_big   = 1'b0;
    dec_rrx   = 1'b0;
    if (imm_flag) begin
      dec_data      = '0;
      dec_data[7:0] = op2_field[7:0];
      dec_ctrl      = 2'b11;
      dec_shamt     = {op2_field[11:8], 1'b0};
    end else if (!reg_shift) begin
      dec_shamt = op2_field[11:7];
      // A zero immediate amount encodes LSR/ASR #32 and RRX.
      if (op2_field[11:7] == 5'd0) begin
        unique case (op2_field[6:5])
          2'b01, 2'b10: dec_s32 = 1'b1;
          2'b11: begin
            dec_rrx   = 1'b1;
            dec_shamt = 5'd1;
          end
          default: dec_shamt = 5'd0;
        endcase
      end
    end else begin
      // Rotates only care about the amount modulo 32.
      if (op2_field[6:5] == 2'b11) begin
        dec_shamt = rs_data[4:0];
      end else if (rs_data < 8'd32) begin
        dec_shamt = rs_data[4:0];
      end else if (rs_data == 8'd32) begin
        dec_s32 = 1'b1;
      end else begin
        dec_big = 1'b1;
      end
    end
  end

  assign entry_d = {dec_data, dec_shamt, dec_ctrl, dec_s32, dec_big, dec_rrx};

  // Readiness comes only from registered occupancy, never from out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Next-state for occupancy and pointers; flush empties the buffer.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The head slot feeds the shifter directly; a push at count 1 writes the
  // other slot, so the head stays stable while stalled.
  assign head = mem_q[rd_ptr_q];
  assign {shift_data, shamt, control, shift32, shift_big, rrx} = head;

endmodule
`default_nettype wire

// File: tb/tb_operand2_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand2_shift_stage
//  Description : Self-checking bench for operand2_shift_stage with a queue
//                based reference model and directed literal scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand2_shift_stage;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  c;
    logic        s32;
    logic        big;
    logic        rrx;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imm_flag = 1'b0;
  logic        reg_shift = 1'b0;
  logic [11:0] op2_field = 12'h000;
  logic [31:0] rm_data = 32'h0;
  logic [7:0]  rs_data = 8'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] shift_data;
  logic [4:0]  shamt;
  logic [1:0]  control;
  logic        shift32;
  logic        shift_big;
  logic        rrx;

  int n_vec = 0;
  int n_err = 0;

  rec_t q[$];

  operand2_shift_stage #(.W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_flag(imm_flag), .reg_shift(reg_shift), .op2_field(op2_field),
    .rm_data(rm_data), .rs_data(rs_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .shift_data(shift_data), .shamt(shamt), .control(control),
    .shift32(shift32), .shift_big(shift_big), .rrx(rrx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, using integer amounts.
  function automatic rec_t decode(input logic imm, input logic rsh,
                                  input logic [11:0] op2, input logic [31:0] rm,
                                  input logic [7:0] rs);
    rec_t r;
    int   amt;
    r.d = rm; r.sh = 0; r.c = op2[6:5]; r.s32 = 0; r.big = 0; r.rrx = 0;
    if (imm) begin
      r.d  = 32'(op2[7:0]);
      r.c  = 2'd3;
      r.sh = 5'(int'(op2[11:8]) * 2);
    end else if (!rsh) begin
      amt = int'(op2[11:7]);
      if (amt != 0) r.sh = 5'(amt);
      else if (r.c == 2'd1 || r.c == 2'd2) r.s32 = 1;
      else if (r.c == 2'd3) begin r.rrx = 1; r.sh = 5'd1; end
    end else begin
      amt = int'(rs);
      if (r.c == 2'd3)  r.sh = 5'(amt % 32);
      else if (amt < 32) r.sh = 5'(amt);
      else if (amt == 32) r.s32 = 1;
      else r.big = 1;
    end
    return r;
  endfunction

  // Reference FIFO: plain queue, decisions taken from pre-edge occupancy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      int   sz;
      logic do_push, do_pop;
      sz      = q.size();
      do_pop  = (sz > 0) && out_ready;
      do_push = in_valid && (sz < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(decode(imm_flag, reg_shift, op2_field, rm_data, rs_data));
      end
    end
  end

  // Every cycle outside reset, the DUT must match the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        chk("shift_data", 64'(shift_data), 64'(q[0].d));
        chk("shamt", 64'(shamt), 64'(q[0].sh));
        chk("control", 64'(control), 64'(q[0].c));
        chk("flags", 64'({shift32, shift_big, rrx}), 64'({q[0].s32, q[0].big, q[0].rrx}));
      end
    end
  end

  task automatic chk_head(input string nm, input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] c, input logic s32, input logic big,
                          input logic rx);
    chk({nm, ".valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".data"}, 64'(shift_data), 64'(d));
    chk({nm, ".shamt"}, 64'(shamt), 64'(sh));
    chk({nm, ".ctrl"}, 64'(control), 64'(c));
    chk({nm, ".flags"}, 64'({shift32, shift_big, rrx}), 64'({s32, big, rx}));
  endtask

  task automatic set_op(input logic imm, input logic rsh, input logic [11:0] op2,
                        input logic [31:0] rm, input logic [7:0] rs);
    imm_flag = imm; reg_shift = rsh; op2_field = op2; rm_data = rm; rs_data = rs;
  endtask

  // Present one operand for a single cycle with the consumer ready.
  task automatic push1(input logic imm, input logic rsh, input logic [11:0] op2,
                       input logic [31:0] rm, input logic [7:0] rs);
    set_op(imm, rsh, op2, rm, rs);
    in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    // Reset state while reset is held.
    #2;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.out", 64'({shift_data, shamt, control, shift32, shift_big, rrx}), 64'd0);
    #10 reset = 0;
    @(posedge clk); #1;

    // Scenario 1: immediate rotate.
    push1(1, 0, 12'h4FF, 32'hDEADBEEF, 8'h00);
    chk_head("s1", 32'h000000FF, 5'd8, 2'b11, 0, 0, 0);
    // Scenario 2: LSR #32 encoding.
    push1(0, 0, 12'h020, 32'h80000000, 8'h00);
    chk_head("s2", 32'h80000000, 5'd0, 2'b01, 1, 0, 0);
    // Scenario 3: RRX encoding.
    push1(0, 0, 12'h060, 32'h00000003, 8'h00);
    chk_head("s3", 32'h00000003, 5'd1, 2'b11, 0, 0, 1);
    // Scenario 4: register amounts.
    push1(0, 1, 12'h010, 32'h12345678, 8'd32);
    chk_head("s4_32", 32'h12345678, 5'd0, 2'b00, 1, 0, 0);
    push1(0, 1, 12'h010, 32'h12345678, 8'd200);
    chk_head("s4_200", 32'h12345678, 5'd0, 2'b00, 0, 1, 0);
    push1(0, 1, 12'h070, 32'h12345678, 8'd36);
    chk_head("s4_ror36", 32'h12345678, 5'd4, 2'b11, 0, 0, 0);
    push1(0, 1, 12'h030, 32'hCAFEF00D, 8'd31);
    chk_head("s4_lsr31", 32'hCAFEF00D, 5'd31, 2'b01, 0, 0, 0);
    @(posedge clk); #1;
    chk("drain.valid", 64'(out_valid), 64'd0);

    // Scenario 5: back-pressure with three entries A, B, C.
    out_ready = 0; in_valid = 1;
    set_op(0, 0, 12'h000, 32'hAAAA0001, 8'h0); @(posedge clk); #1;
    set_op(0, 0, 12'h000, 32'hBBBB0002, 8'h0); @(posedge clk); #1;
    chk("s5.full_ready", 64'(in_ready), 64'd0);
    set_op(0, 0, 12'h000, 32'hCCCC0003, 8'h0); @(posedge clk); #1;
    chk_head("s5.holdA", 32'hAAAA0001, 5'd0, 2'b00, 0, 0, 0);
    out_ready = 1; @(posedge clk); #1;
    chk_head("s5.B", 32'hBBBB0002, 5'd0, 2'b00, 0, 0, 0);
    chk("s5.ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    chk_head("s5.C", 32'hCCCC0003, 5'd0, 2'b00, 0, 0, 0);
    @(posedge clk); #1;
    chk("s5.empty", 64'(out_valid), 64'd0);

    // Scenario 6: flush at full, then asynchronous reset mid-cycle.
    out_ready = 0; in_valid = 1;
    set_op(1, 0, 12'h111, 32'h0, 8'h0); @(posedge clk); #1;
    set_op(1, 0, 12'h222, 32'h0, 8'h0); @(posedge clk); #1;
    flush = 1; @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("s6.flush_valid", 64'(out_valid), 64'd0);
    chk("s6.flush_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("s6.nothing", 64'(out_valid), 64'd0);
    in_valid = 1; set_op(1, 0, 12'h3AB, 32'h0, 8'h0);
    @(posedge clk); #1;
    in_valid = 0;
    #2 reset = 1;
    #1;
    chk("s6.rst_valid", 64'(out_valid), 64'd0);
    chk("s6.rst_ready", 64'(in_ready), 64'd1);
    chk("s6.rst_out", 64'({shift_data, shamt, control, shift32, shift_big, rrx}), 64'd0);
    #3 reset = 0;
    in_valid = 1; out_ready = 0; set_op(1, 0, 12'h2C5, 32'h0, 8'h0);
    @(posedge clk); #1;
    in_valid = 0;
    chk_head("s6.first", 32'h000000C5, 5'd4, 2'b11, 0, 0, 0);
    out_ready = 1;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      imm_flag  = ($urandom_range(0, 3) == 0);
      reg_shift = $urandom_range(0, 1);
      op2_field = 12'($urandom);
      if ($urandom_range(0, 3) == 0) op2_field[11:7] = 5'd0;
      rm_data   = $urandom;
      case ($urandom_range(0, 4))
        0:       rs_data = 8'd32;
        1:       rs_data = 8'($urandom_range(0, 31));
        2:       rs_data = 8'($urandom_range(33, 255));
        default: rs_data = 8'($urandom);
      endcase
      @(posedge clk); #1;
    end
    flush = 0; in_valid = 0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
